// File: rtl/render_pkg.sv
// Shared types and constants for the triangle rasterizer frame scheduler.
package render_pkg;

  localparam int COORD_WIDTH_DEF = 32;
  localparam int VERTS_PER_TRI   = 3;
  localparam int Q_FRAC_BITS     = 16;
  localparam logic [31:0] Q_ONE  = 32'h0001_0000;

  typedef logic [3*COORD_WIDTH_DEF-1:0] vertex_t;
  typedef vertex_t [2:0] triangle_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } sched_state_e;

endpackage

// File: rtl/vertex_fetch.sv
// Issues the three vertex reads of one triangle and captures the BRAM
// returns, using a latency-deep valid/index pipe to line data up with reads.
module vertex_fetch
  import render_pkg::*;
#(
  parameter int COORD_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               addr,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic [3*COORD_WIDTH-1:0]            mem_data,
  output logic [2:0][2:0][COORD_WIDTH-1:0]    verts,
  output logic                                fetch_done
);

  logic                        issue_v;
  logic [1:0]                  issue_k;
  logic [MEM_LATENCY-1:0]      sr_v;
  logic [MEM_LATENCY-1:0][1:0] sr_k;

  assign fetch_done = sr_v[MEM_LATENCY-1] && (sr_k[MEM_LATENCY-1] == 2'(VERTS_PER_TRI-1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_addr <= '0;
      issue_v  <= 1'b0;
      issue_k  <= 2'd0;
      sr_v     <= '0;
      sr_k     <= '0;
      verts    <= '0;
    end else begin
      if (start) begin
        mem_addr <= addr;
        issue_k  <= 2'd0;
        issue_v  <= 1'b1;
      end else if (issue_v && (issue_k != 2'(VERTS_PER_TRI-1))) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
        issue_k  <= issue_k + 2'd1;
      end else begin
        issue_v  <= 1'b0;
      end
      // sr_v[i] marks a read issued i+1 cycles ago; the last tap is data-valid
      sr_v[0] <= issue_v;
      sr_k[0] <= issue_k;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_k[i] <= sr_k[i-1];
      end
      if (sr_v[MEM_LATENCY-1]) begin
        verts[sr_k[MEM_LATENCY-1]] <= mem_data;
      end
    end
  end

endmodule

// File: rtl/mesh_render_scheduler.sv
// Frame sequencer: walks a triangle list and feeds the rasterizer one triangle at a time.
// Optional RENDER_STATS_EN adds frame cycle, triangle and dropped-start counters.
module mesh_render_scheduler
  import render_pkg::*;
#(
  parameter int COORD_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MAX_TRIS    = 1024,
  parameter int MEM_LATENCY = 2,
  localparam int NW = $clog2(MAX_TRIS+1),
  localparam int IW = $clog2(MAX_TRIS)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              frame_start,
  input  logic [NW-1:0]                     num_tris,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [3*COORD_WIDTH-1:0]          mem_data,
  output logic [2:0][2:0][COORD_WIDTH-1:0]  tri_verts,
  output logic                              raster_start,
  input  logic                              raster_busy,
  input  logic                              raster_done,
  output logic                              busy,
  output logic                              frame_done,
`ifdef RENDER_STATS_EN
  output logic [31:0]                       stat_frame_cycles,
  output logic [NW-1:0]                     stat_tris,
  output logic [15:0]                       stat_dropped,
`endif
  output logic [IW-1:0]                     tri_idx
);

  sched_state_e          state;
  logic [NW-1:0]         n_r;
  logic [NW-1:0]         n_in;
  logic [ADDR_WIDTH-1:0] tri_base;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_go;
  logic                  fetch_done;
  logic                  accept;
  logic                  last_tri;

  assign n_in     = (num_tris > NW'(MAX_TRIS)) ? NW'(MAX_TRIS) : num_tris;
  assign accept   = (state == S_IDLE) && frame_start && !raster_busy;
  assign last_tri = (NW'(tri_idx) == (n_r - NW'(1)));

  // Fetch is kicked on the same edge the FSM enters FETCH, so reads start in its first cycle
  always_comb begin
    fetch_go   = 1'b0;
    fetch_addr = tri_base;
    if (accept) begin
      fetch_go   = (n_in != '0);
      fetch_addr = base_addr;
    end else if ((state == S_WAIT) && raster_done && !last_tri) begin
      fetch_go   = 1'b1;
      fetch_addr = tri_base + ADDR_WIDTH'(3);
    end else begin
      fetch_go   = 1'b0;
      fetch_addr = tri_base;
    end
  end

  vertex_fetch #(
    .COORD_WIDTH (COORD_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_fetch (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start      (fetch_go),
    .addr       (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .verts      (tri_verts),
    .fetch_done (fetch_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      n_r          <= '0;
      tri_base     <= '0;
      tri_idx      <= '0;
      raster_start <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      raster_start <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            n_r      <= n_in;
            tri_base <= base_addr;
            tri_idx  <= '0;
            busy     <= 1'b1;
            state    <= (n_in == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_done) begin
            raster_start <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (raster_done) begin
            if (last_tri) begin
              state <= S_FINISH;
            end else begin
              tri_idx  <= tri_idx + IW'(1);
              tri_base <= fetch_addr;
              state    <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RENDER_STATS_EN
  logic [31:0]   cyc_cnt;
  logic [NW-1:0] tri_cnt;

  // cyc_cnt counts the accept cycle as 1; FINISH adds itself plus the frame_done cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_cnt           <= 32'd0;
      tri_cnt           <= '0;
      stat_frame_cycles <= 32'd0;
      stat_tris         <= '0;
      stat_dropped      <= 16'd0;
    end else begin
      if (accept) begin
        cyc_cnt <= 32'd1;
        tri_cnt <= '0;
      end else if (state != S_IDLE) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if ((state == S_WAIT) && raster_done) begin
        tri_cnt <= tri_cnt + NW'(1);
      end
      if (state == S_FINISH) begin
        stat_frame_cycles <= cyc_cnt + 32'd2;
        stat_tris         <= tri_cnt;
      end
      if (frame_start && !accept && (stat_dropped != 16'hFFFF)) begin
        stat_dropped <= stat_dropped + 16'd1;
      end
    end
  end
`endif

endmodule
